sseg_scan_n: RTL and testbench
==============================

Name: sseg_scan_n

Overview:
- Parametrised, time-multiplexed N-digit seven-segment display driver. Next generation of the two-digit static display path.
- Accepts a binary value and shows it in hex or in decimal. Decimal mode uses a sequential double-dabble converter.
- Adds a refresh scan counter, per-digit decimal points, leading-zero blanking and an overflow indication.
- Sits between the switch/register logic and the board anode/cathode pins (active-low anodes, segments and dp).

Parameters:
- NUM_DIGITS, 4, number of digits scanned; must be at least 2.
- REFRESH_DIV, 100000, clk cycles each digit stays lit; must be at least 2.
- DATA_W, 16, width of the binary input value; must be at most 4*NUM_DIGITS.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- value  input  DATA_W  binary value to display
- load  input  1  capture value and mode; honoured only when busy=0
- mode  input  1  0 = hex, 1 = decimal
- blank_lz  input  1  1 = blank leading zero digits
- dp_in  input  NUM_DIGITS  per-digit decimal point request, active-high; bit 0 = rightmost digit
- busy  output  1  decimal conversion in progress
- overflow  output  1  last decimal value exceeded NUM_DIGITS digits
- an  output  NUM_DIGITS  digit anodes, active-low; bit 0 = rightmost digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

Behaviour:
- Reset (async, any time, including mid-conversion):
  - an = all ones, seg = 7'h7F, dp = 1, busy = 0, overflow = 0.
  - Display nibble register cleared, latched mode = hex, refresh counter = 0, digit index = 0.
  - Any conversion in progress is aborted.
- Load, hex mode (load=1, busy=0, mode=0):
  - On that edge, display nibbles get value zero-extended to 4*NUM_DIGITS bits; overflow cleared.
  - busy stays 0.
- Load, decimal mode (load=1, busy=0, mode=1):
  - On that edge, value is copied to the shift register, the BCD accumulator (4*(NUM_DIGITS+1) bits) is cleared, and busy goes to 1.
  - Each following cycle performs one double-dabble step: add 3 to every BCD nibble >= 5, then shift left 1 bit, bringing in the value MSB.
  - After exactly DATA_W steps, on the edge that completes the last step:
    - The low NUM_DIGITS BCD nibbles are written to the display register.
    - overflow = OR of the extra top nibble.
    - busy goes to 0.
  - busy is high for exactly DATA_W cycles.
  - The display keeps its previous contents until that final write.
- load while busy=1 is ignored; value and mode are only sampled on an accepted load.
- Conversion FSM states:
  - IDLE goes to CONV on an accepted decimal load.
  - CONV goes to IDLE when the step count reaches DATA_W.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index increments, going from NUM_DIGITS-1 back to 0.
  - an, seg and dp are registered, so they lag the index/data by one cycle.
  - an = ~(1 << index).
  - dp = ~dp_in[index], sampled live.
- Decode table, hex nibble to seg:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Overflow display: when overflow=1, every digit shows a dash (seg = 7'h3F), and blanking is ignored.
- Leading-zero blanking:
  - Applies when blank_lz=1, index > 0, and all display nibbles from index up to NUM_DIGITS-1 are zero.
  - A blanked digit gets seg = 7'h7F; its anode is still driven and dp_in still applies.
  - Digit 0 is never blanked, so value 0 shows "0".
  - blank_lz and dp_in are live inputs with no capture.
- Simultaneous events: a load accepted on the same edge as a scan wrap updates both. The newly selected digit shows old data for that cycle and new data from the next cycle.

Test Plan:
- Reset, then release with REFRESH_DIV=4 and NUM_DIGITS=4 -> an cycles 1110, 1101, 1011, 0111, each for 4 clk cycles; seg=7'h40 on every digit; busy=0.
- Hex load of value=16'hA5C3 -> after one edge, digits 3..0 show seg 08, 12, 46, 30.
- Decimal load of value=16'd1234 -> busy high for exactly 16 cycles; digits then show 1, 2, 3, 4 (79, 24, 30, 19); overflow=0; a second load pulsed during busy is ignored.
- Decimal load of 16'd65535 -> overflow=1 and all digits show seg=7'h3F; a following hex load of 16'h0001 clears overflow.
- Decimal load of 16'd7 with blank_lz=1 and dp_in=4'b0100 -> digits 3 and 1 show seg=7'h7F; digit 2 shows seg=7'h7F with dp=0; digit 0 shows 78.
- rst asserted 5 cycles into a decimal conversion -> outputs return to reset values immediately (asynchronously); after release, busy=0 and the display shows 0.

Source files
------------

// File: rtl/sseg_scan_n.sv
// Time-multiplexed N-digit seven-segment driver with hex or decimal display.
// A sequential double-dabble converter handles decimal mode. All outputs are active-low.
module sseg_scan_n #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DATA_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     value,
    input  logic                  load,
    input  logic                  mode,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int STEP_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int BCD_W  = 4 * (NUM_DIGITS + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DATA_W - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t                     state, state_next;
    logic [NUM_DIGITS-1:0][3:0] disp;
    logic [NUM_DIGITS:0][3:0]   bcd, bcd_adj, bcd_next;
    logic [BCD_W-1:0]           adj_flat;
    logic [DATA_W-1:0]          shift;
    logic [STEP_W-1:0]          step;
    logic                       mode_q;
    logic [CNT_W-1:0]           cnt;
    logic [IDX_W-1:0]           idx;
    logic [DISP_W-1:0]          value_ext;
    logic [NUM_DIGITS-1:0]      zero_from;
    logic                       run_zero;
    logic                       blank;
    logic [6:0]                 seg_next;
    logic                       accept;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    assign accept = (state == IDLE) && load;
    assign busy   = (state == CONV);

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && mode)     state_next = CONV;
            CONV:    if (step == STEP_LAST)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        value_ext = '0;
        value_ext[DATA_W-1:0] = value;
    end

    // One double-dabble step: add 3 to BCD nibbles >= 5, then shift in the next value bit.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i <= NUM_DIGITS; i++) begin
            if (bcd[i] >= 4'd5) bcd_adj[i] = bcd[i] + 4'd3;
        end
        adj_flat = bcd_adj;
        bcd_next = {adj_flat[BCD_W-2:0], shift[DATA_W-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp     <= '0;
            overflow <= 1'b0;
            mode_q   <= 1'b0;
            shift    <= '0;
            bcd      <= '0;
            step     <= '0;
        end else if (accept) begin
            mode_q <= mode;
            if (mode) begin
                shift <= value;
                bcd   <= '0;
                step  <= '0;
            end else begin
                disp     <= value_ext;
                overflow <= 1'b0;
            end
        end else if (state == CONV) begin
            bcd   <= bcd_next;
            shift <= shift << 1;
            step  <= step + 1'b1;
            if (step == STEP_LAST) begin
                disp     <= bcd_next[NUM_DIGITS-1:0];
                overflow <= |bcd_next[NUM_DIGITS];
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        zero_from = '0;
        run_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero     = run_zero && (disp[i] == 4'h0);
            zero_from[i] = run_zero;
        end
        blank    = blank_lz && (idx != '0) && zero_from[idx];
        seg_next = decode(disp[idx]);
        if (overflow && mode_q) seg_next = 7'h3F;
        else if (blank)         seg_next = 7'h7F;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= seg_next;
            dp  <= ~dp_in[idx];
        end
    end

endmodule

// File: tb/tb_sseg_scan_n.sv
// Scoreboard bench for sseg_scan_n: expected digit frames come from a reference model,
// are queued at load time and compared as each digit is scanned out.
module tb_sseg_scan_n;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] value;
    logic          load;
    logic          mode;
    logic          blank_lz;
    logic [ND-1:0] dp_in;
    logic          busy;
    logic          overflow;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;

    sseg_scan_n #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .mode(mode),
        .blank_lz(blank_lz), .dp_in(dp_in), .busy(busy), .overflow(overflow),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] m_nib [ND];
    logic       m_ovf;

    typedef struct {
        string      tag;
        int         digit;
        logic [6:0] seg;
        logic       dp;
    } exp_t;
    exp_t sb [$];

    function automatic logic [6:0] model_seg(input int d);
        bit all_zero = 1'b1;
        if (m_ovf) return 7'h3F;
        for (int i = d; i < ND; i++) if (m_nib[i] != 4'h0) all_zero = 1'b0;
        if (blank_lz && d > 0 && all_zero) return 7'h7F;
        return seg_tab[m_nib[d]];
    endfunction

    task automatic model_hex(input logic [DW-1:0] v);
        for (int d = 0; d < ND; d++) m_nib[d] = v[4*d +: 4];
        m_ovf = 1'b0;
    endtask

    task automatic model_dec(input int v);
        int t = v;
        for (int d = 0; d < ND; d++) begin
            m_nib[d] = 4'(t % 10);
            t = t / 10;
        end
        m_ovf = (t % 10) != 0;
    endtask

    task automatic push_frame(input string tag);
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            e.tag   = tag;
            e.digit = d;
            e.seg   = model_seg(d);
            e.dp    = ~dp_in[d];
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        exp_t       e;
        logic [3:0] want;
        bit         found;
        while (sb.size() > 0) begin
            e     = sb.pop_front();
            want  = 4'b0001 << e.digit;
            want  = ~want;
            found = 1'b0;
            for (int i = 0; i < 4 * RD * ND + 8; i++) begin
                @(negedge clk);
                if (an === want) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) begin
                check($sformatf("%s_d%0d_timeout", e.tag, e.digit), 32'd0, 32'd1);
            end else begin
                check($sformatf("%s_d%0d_seg", e.tag, e.digit), 32'(seg), 32'(e.seg));
                check($sformatf("%s_d%0d_dp", e.tag, e.digit), 32'(dp), 32'(e.dp));
            end
        end
    endtask

    task automatic do_load(input logic [DW-1:0] v, input logic m);
        @(negedge clk);
        value = v;
        mode  = m;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Counts busy cycles from the first sample after the load edge; optionally pokes a load mid-conversion.
    task automatic wait_conv(input string tag, input bit inject);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            n++;
            if (inject && n == 3) begin
                load  = 1'b1;
                mode  = 1'b0;
                value = 16'hFFFF;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'(DW));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] want_an;
        rst = 1'b1; load = 1'b0; mode = 1'b0; value = '0;
        blank_lz = 1'b0; dp_in = '0;
        #3;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Scan sequence from reset: each anode lit for RD cycles, display shows zeros.
        for (int k = 1; k <= RD * ND; k++) begin
            @(negedge clk);
            want_an = 4'b0001 << ((k - 1) / RD);
            want_an = ~want_an;
            check($sformatf("scan_an_%0d", k), 32'(an), 32'(want_an));
            check($sformatf("scan_seg_%0d", k), 32'(seg), 32'h40);
        end
        check("scan_busy", 32'(busy), 32'd0);

        do_load(16'hA5C3, 1'b0);
        check("hex_busy", 32'(busy), 32'd0);
        check("hex_ovf", 32'(overflow), 32'd0);
        model_hex(16'hA5C3);
        repeat (2) @(negedge clk);
        push_frame("hex_a5c3");
        drain();

        do_load(16'd1234, 1'b1);
        wait_conv("dec1234", 1'b1);
        model_dec(1234);
        check("dec1234_ovf", 32'(overflow), 32'(m_ovf));
        repeat (2) @(negedge clk);
        push_frame("dec1234");
        drain();

        do_load(16'd65535, 1'b1);
        wait_conv("dec65535", 1'b0);
        model_dec(65535);
        check("dec65535_ovf", 32'(overflow), 32'd1);
        repeat (2) @(negedge clk);
        push_frame("ovf");
        drain();

        do_load(16'h0001, 1'b0);
        model_hex(16'h0001);
        check("hex1_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        push_frame("hex_0001");
        drain();

        blank_lz = 1'b1;
        dp_in    = 4'b0100;
        do_load(16'd7, 1'b1);
        wait_conv("dec7", 1'b0);
        model_dec(7);
        repeat (2) @(negedge clk);
        push_frame("blank7");
        drain();

        // Reset in the middle of a conversion, away from any clock edge.
        dp_in = '0;
        do_load(16'd1234, 1'b1);
        repeat (4) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_dp", 32'(dp), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_hex('0);
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        push_frame("post_rst");
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
